switch_mcu_regfile_ctrl: RTL and testbench
==========================================

Name: switch_mcu_regfile_ctrl

Overview:
Access controller for the MCU 32x32 register file. The register file has one write port and two registered read ports with 1-cycle latency. This block arbitrates the single write port between ALU writeback (WB) and load returns (LD), with starvation protection. It keeps a load scoreboard and sequences decode reads, stalling on RAW/WAW hazards so that decode never reads a stale register.

Parameters:
STARVE_MAX, 4, consecutive cycles LD may be refused before it gets priority (range 1..15)

Ports:
in_clk  input  1  clock
in_rst  input  1  reset, asynchronous, active-low
in_wb_valid  input  1  WB write request
in_wb_addr  input  5  WB destination register
in_wb_data  input  32  WB data
out_wb_ready  output  1  WB accepted this cycle (combinational)
in_ld_valid  input  1  load-return write request
in_ld_addr  input  5  load destination register
in_ld_data  input  32  load data
out_ld_ready  output  1  LD accepted this cycle (combinational)
in_iss_valid  input  1  instruction issuing
in_iss_rd  input  5  issuing instruction destination
in_iss_is_load  input  1  issuing instruction is a load
out_iss_stall  output  1  issue must hold (combinational)
in_rd_req  input  1  decode requests operand read
in_rs1  input  5  source 1 address
in_rs1_en  input  1  source 1 used
in_rs2  input  5  source 2 address
in_rs2_en  input  1  source 2 used
out_rd_stall  output  1  read refused this cycle (combinational)
out_rdata_valid  output  1  register-file read data valid this cycle
out_rf_wen  output  1  to register-file write enable (registered)
out_rf_waddr  output  5  to register-file write address (registered)
out_rf_wdata  output  32  to register-file write data (registered)
out_rf_ren_1  output  1  to register-file read port 1 enable (combinational)
out_rf_raddr_1  output  5  read port 1 address
out_rf_ren_2  output  1  read port 2 enable
out_rf_raddr_2  output  5  read port 2 address
out_busy  output  32  scoreboard vector (debug)

Behaviour:
- Reset (in_rst low, any time, asynchronous): busy=0, starve count=0, out_rf_wen=0, out_rf_waddr=0, out_rf_wdata=0, out_rdata_valid=0. All in-flight writes and reads are dropped.
- Write arbitration, default mode: WB wins. out_wb_ready=in_wb_valid; out_ld_ready=in_ld_valid & !in_wb_valid.
- Starve count: increments on each cycle with in_ld_valid & !out_ld_ready, saturating at STARVE_MAX. Clears on LD accept.
- Priority mode (count==STARVE_MAX): LD wins. out_ld_ready=in_ld_valid; out_wb_ready=in_wb_valid & !in_ld_valid. After LD is accepted, the block returns to default mode.
- At most one accept per cycle. The accepted request is registered into out_rf_*, so the register file captures it one edge later: 2-edge write latency.
- Writes to x0 are accepted but give out_rf_wen=0.
- No accept in a cycle gives out_rf_wen=0 the next cycle.
- Scoreboard set: on an edge with in_iss_valid & in_iss_is_load & !out_iss_stall & in_iss_rd!=0, set busy[in_iss_rd].
- Scoreboard clear: on an edge with out_rf_wen=1 from an LD-sourced write, clear busy[out_rf_waddr].
- Set and clear of the same register on the same edge: set wins.
- busy[0] is always 0.
- out_iss_stall = in_iss_valid & busy[in_iss_rd]. This prevents WAW behind an outstanding load.
- Read hazard for source s (s enabled, s!=0) exists if any of:
  - busy[s];
  - out_rf_wen & out_rf_waddr==s (pending registered write);
  - a write to s accepted this cycle.
- out_rd_stall = in_rd_req & (hazard on rs1 | hazard on rs2).
- Read issue: when in_rd_req & !out_rd_stall, drive out_rf_ren_1=in_rs1_en, out_rf_raddr_1=in_rs1, out_rf_ren_2=in_rs2_en, out_rf_raddr_2=in_rs2. Otherwise the enables are 0 and the addresses are 0.
- out_rdata_valid is asserted on the cycle after an issued read: 1-cycle read latency, matching the register-file read register.
- Back-to-back reads are allowed every cycle.
- A read issued on the cycle after busy clears returns the new value.
- LD returning to a non-busy register (spurious): the write is performed and the scoreboard is unchanged.

Test Plan:
- Reset mid-write: hold WB valid addr 5 data 0xA5A5A5A5, assert in_rst low between accept and write. Required: out_rf_wen=0 immediately, register 5 not written, busy=0.
- WB priority and starvation (STARVE_MAX=4): WB and LD valid every cycle. Required: WB is accepted 4 cycles, LD is accepted on the 5th cycle (out_wb_ready=0 that cycle), then WB wins again.
- Load RAW: issue load to x7. Required: busy[7]=1. Decode reads rs1=x7 and stalls until LD writes 0x12345678. The read issues on the cycle after busy[7] clears, and the data is valid 1 cycle later.
- WAW: issue load x3, then an ALU instruction with rd=x3. Required: out_iss_stall=1 until the LD write to x3 completes.
- x0 handling: WB write to x0 with data 0xFFFFFFFF, load issued to x0. Required: out_rf_wen=0, busy stays 0, a read of x0 never stalls.
- Pending-write RAW: WB writes x9 in cycle N, decode reads x9 in cycles N and N+1. Required: stall in both cycles, read issues in cycle N+2 and returns the new value.

Source files
------------

// File: rtl/switch_mcu_regfile_ctrl.sv
// -----------------------------------------------------------------------------
// switch_mcu_regfile_ctrl
//
// Access controller for the MCU 32x32 register file (one write port, two
// registered read ports with 1-cycle latency).
//   - Arbitrates the single write port between ALU writeback (WB) and load
//     returns (LD). WB wins by default; an LD refused STARVE_MAX times in a
//     row is given priority for its next attempt.
//   - Keeps a load scoreboard (busy) that is set when a load issues and cleared
//     when that load's data reaches the register file.
//   - Sequences decode operand reads, refusing them while a source register
//     has an outstanding load, a registered write in flight, or a write being
//     accepted in the same cycle, so decode never observes a stale value.
//
// Ports:
//   in_clk, in_rst            clock, asynchronous active-low reset
//   in_wb_* / out_wb_ready    WB write request and same-cycle accept
//   in_ld_* / out_ld_ready    load-return write request and same-cycle accept
//   in_iss_* / out_iss_stall  instruction issue and WAW hold
//   in_rd_req, in_rs*         decode operand read request
//   out_rd_stall              read refused this cycle
//   out_rdata_valid           register-file read data valid (cycle after issue)
//   out_rf_w*                 registered write port to the register file
//   out_rf_ren_*/raddr_*      read-port enables and addresses
//   out_busy                  scoreboard vector (debug)
// -----------------------------------------------------------------------------
module switch_mcu_regfile_ctrl #(
  parameter int unsigned STARVE_MAX = 32'd4
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_wb_valid,
  input  logic [4:0]  in_wb_addr,
  input  logic [31:0] in_wb_data,
  output logic        out_wb_ready,
  input  logic        in_ld_valid,
  input  logic [4:0]  in_ld_addr,
  input  logic [31:0] in_ld_data,
  output logic        out_ld_ready,
  input  logic        in_iss_valid,
  input  logic [4:0]  in_iss_rd,
  input  logic        in_iss_is_load,
  output logic        out_iss_stall,
  input  logic        in_rd_req,
  input  logic [4:0]  in_rs1,
  input  logic        in_rs1_en,
  input  logic [4:0]  in_rs2,
  input  logic        in_rs2_en,
  output logic        out_rd_stall,
  output logic        out_rdata_valid,
  output logic        out_rf_wen,
  output logic [4:0]  out_rf_waddr,
  output logic [31:0] out_rf_wdata,
  output logic        out_rf_ren_1,
  output logic [4:0]  out_rf_raddr_1,
  output logic        out_rf_ren_2,
  output logic [4:0]  out_rf_raddr_2,
  output logic [31:0] out_busy
);

  localparam logic [3:0] STARVE_MAX_C = STARVE_MAX[3:0];

  // Read hazard on one source: enabled non-x0 source that is awaiting a load,
  // has a registered write in flight, or is being written by this cycle's accept.
  function automatic logic src_hazard(
    input logic        en,
    input logic [4:0]  src,
    input logic [31:0] busy,
    input logic        pend_wen,
    input logic [4:0]  pend_addr,
    input logic        acc,
    input logic [4:0]  acc_addr
  );
    src_hazard = en & (src != 5'd0) &
                 (busy[src] | (pend_wen & (pend_addr == src)) | (acc & (acc_addr == src)));
  endfunction

  logic [3:0]  starve_cnt_r;
  logic        prio_s;
  logic        wb_acc_s;
  logic        ld_acc_s;
  logic        acc_s;
  logic [4:0]  acc_addr_s;
  logic [31:0] acc_data_s;

  logic        rf_wen_r;
  logic [4:0]  rf_waddr_r;
  logic [31:0] rf_wdata_r;
  logic        rf_src_ld_r;

  logic [31:0] busy_r;
  logic [31:0] busy_nxt_s;
  logic        iss_set_s;
  logic        ld_clr_s;

  logic        haz1_s;
  logic        haz2_s;
  logic        rd_issue_s;
  logic        rdata_valid_r;

  // Write-port arbitration: WB by default, LD once it has been starved long enough.
  always_comb begin
    prio_s   = (starve_cnt_r == STARVE_MAX_C);
    wb_acc_s = 1'b0;
    ld_acc_s = 1'b0;
    if (prio_s) begin
      ld_acc_s = in_ld_valid;
      wb_acc_s = in_wb_valid & ~in_ld_valid;
    end else begin
      wb_acc_s = in_wb_valid;
      ld_acc_s = in_ld_valid & ~in_wb_valid;
    end
    acc_s = wb_acc_s | ld_acc_s;
    if (ld_acc_s) begin
      acc_addr_s = in_ld_addr;
      acc_data_s = in_ld_data;
    end else begin
      acc_addr_s = in_wb_addr;
      acc_data_s = in_wb_data;
    end
  end

  assign out_wb_ready = wb_acc_s;
  assign out_ld_ready = ld_acc_s;

  // Starvation counter: counts refused LD cycles, saturates, clears on LD accept.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      starve_cnt_r <= 4'd0;
    end else if (ld_acc_s) begin
      starve_cnt_r <= 4'd0;
    end else if (in_ld_valid && (starve_cnt_r != STARVE_MAX_C)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Registered write port; x0 writes are accepted but never enabled.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      rf_wen_r    <= 1'b0;
      rf_waddr_r  <= 5'd0;
      rf_wdata_r  <= 32'd0;
      rf_src_ld_r <= 1'b0;
    end else if (acc_s && (acc_addr_s != 5'd0)) begin
      rf_wen_r    <= 1'b1;
      rf_waddr_r  <= acc_addr_s;
      rf_wdata_r  <= acc_data_s;
      rf_src_ld_r <= ld_acc_s;
    end else begin
      rf_wen_r    <= 1'b0;
      rf_waddr_r  <= 5'd0;
      rf_wdata_r  <= 32'd0;
      rf_src_ld_r <= 1'b0;
    end
  end

  assign out_rf_wen   = rf_wen_r;
  assign out_rf_waddr = rf_waddr_r;
  assign out_rf_wdata = rf_wdata_r;

  // An issuing instruction whose destination awaits a load must hold (no WAW).
  assign out_iss_stall = in_iss_valid & busy_r[in_iss_rd];
  assign iss_set_s     = in_iss_valid & in_iss_is_load & ~out_iss_stall & (in_iss_rd != 5'd0);
  assign ld_clr_s      = rf_wen_r & rf_src_ld_r;

  // Scoreboard next state: set beats clear on the same register, x0 never busy.
  always_comb begin
    busy_nxt_s = 32'd0;
    for (int i = 1; i < 32; i++) begin
      busy_nxt_s[i] = (iss_set_s & (in_iss_rd == 5'(i))) |
                      (busy_r[i] & ~(ld_clr_s & (rf_waddr_r == 5'(i))));
    end
  end

  // Scoreboard register.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign out_busy = busy_r;

  assign haz1_s       = src_hazard(in_rs1_en, in_rs1, busy_r, rf_wen_r, rf_waddr_r, acc_s, acc_addr_s);
  assign haz2_s       = src_hazard(in_rs2_en, in_rs2, busy_r, rf_wen_r, rf_waddr_r, acc_s, acc_addr_s);
  assign out_rd_stall = in_rd_req & (haz1_s | haz2_s);
  assign rd_issue_s   = in_rd_req & ~out_rd_stall;

  assign out_rf_ren_1   = rd_issue_s & in_rs1_en;
  assign out_rf_raddr_1 = rd_issue_s ? in_rs1 : 5'd0;
  assign out_rf_ren_2   = rd_issue_s & in_rs2_en;
  assign out_rf_raddr_2 = rd_issue_s ? in_rs2 : 5'd0;

  // Read data valid tracks the register file's 1-cycle read register.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      rdata_valid_r <= 1'b0;
    end else begin
      rdata_valid_r <= rd_issue_s;
    end
  end

  assign out_rdata_valid = rdata_valid_r;

endmodule

// File: tb/tb_switch_mcu_regfile_ctrl.sv
module tb_switch_mcu_regfile_ctrl;
  localparam int STARVE_MAX = 4;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_wb_valid, in_ld_valid, in_iss_valid, in_iss_is_load;
  logic [4:0]  in_wb_addr, in_ld_addr, in_iss_rd, in_rs1, in_rs2;
  logic [31:0] in_wb_data, in_ld_data;
  logic        in_rd_req, in_rs1_en, in_rs2_en;
  logic        out_wb_ready, out_ld_ready, out_iss_stall, out_rd_stall, out_rdata_valid;
  logic        out_rf_wen, out_rf_ren_1, out_rf_ren_2;
  logic [4:0]  out_rf_waddr, out_rf_raddr_1, out_rf_raddr_2;
  logic [31:0] out_rf_wdata, out_busy;

  int vectors = 0;
  int miscompares = 0;

  switch_mcu_regfile_ctrl #(.STARVE_MAX(STARVE_MAX)) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_wb_valid(in_wb_valid), .in_wb_addr(in_wb_addr), .in_wb_data(in_wb_data), .out_wb_ready(out_wb_ready),
    .in_ld_valid(in_ld_valid), .in_ld_addr(in_ld_addr), .in_ld_data(in_ld_data), .out_ld_ready(out_ld_ready),
    .in_iss_valid(in_iss_valid), .in_iss_rd(in_iss_rd), .in_iss_is_load(in_iss_is_load), .out_iss_stall(out_iss_stall),
    .in_rd_req(in_rd_req), .in_rs1(in_rs1), .in_rs1_en(in_rs1_en), .in_rs2(in_rs2), .in_rs2_en(in_rs2_en),
    .out_rd_stall(out_rd_stall), .out_rdata_valid(out_rdata_valid),
    .out_rf_wen(out_rf_wen), .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
    .out_rf_ren_1(out_rf_ren_1), .out_rf_raddr_1(out_rf_raddr_1),
    .out_rf_ren_2(out_rf_ren_2), .out_rf_raddr_2(out_rf_raddr_2),
    .out_busy(out_busy)
  );

  always #5 in_clk = ~in_clk;

  // Behavioural register file attached to the controller's ports.
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  logic [31:0] rf_rdata_1 = 32'h0;
  logic [31:0] rf_rdata_2 = 32'h0;
  always @(posedge in_clk) begin
    if (out_rf_wen) rf_mem[out_rf_waddr] <= out_rf_wdata;
    if (out_rf_ren_1) rf_rdata_1 <= rf_mem[out_rf_raddr_1];
    if (out_rf_ren_2) rf_rdata_2 <= rf_mem[out_rf_raddr_2];
  end

  // Reference model state (architectural view).
  logic [31:0] m_committed [32] = '{default: 32'h0};  // values that reached the RF
  logic [31:0] m_latest    [32] = '{default: 32'h0};  // newest accepted value per register
  logic [31:0] m_busy;
  int          m_starve;
  bit          m_pend, m_pend_ld;
  logic [4:0]  m_pend_addr;
  logic [31:0] m_pend_data;
  bit          m_rdv, m_en1, m_en2;
  logic [31:0] m_exp1, m_exp2;
  // expected combinational outputs for the current inputs
  bit e_wb_rdy, e_ld_rdy, e_acc, e_iss_stall, e_rd_stall, e_issue;
  logic [4:0] e_acc_addr;

  task automatic model_reset();
    m_busy = 32'h0; m_starve = 0; m_pend = 0; m_pend_ld = 0; m_rdv = 0;
    for (int i = 0; i < 32; i++) m_latest[i] = m_committed[i];
  endtask

  function automatic bit hz(bit en, logic [4:0] s);
    return en && s != 5'd0 && (m_busy[s] || (m_pend && m_pend_addr == s) || (e_acc && e_acc_addr == s));
  endfunction

  task automatic model_eval();
    bit prio;
    prio = (m_starve == STARVE_MAX);
    e_ld_rdy = in_ld_valid && (prio || !in_wb_valid);
    e_wb_rdy = in_wb_valid && !(prio && in_ld_valid);
    e_acc = e_wb_rdy || e_ld_rdy;
    e_acc_addr = e_ld_rdy ? in_ld_addr : in_wb_addr;
    e_iss_stall = in_iss_valid && m_busy[in_iss_rd];
    e_rd_stall = in_rd_req && (hz(in_rs1_en, in_rs1) || hz(in_rs2_en, in_rs2));
    e_issue = in_rd_req && !e_rd_stall;
  endtask

  // Advance one clock edge, updating the model with the inputs applied this cycle.
  task automatic step();
    logic [31:0] d;
    model_eval();
    @(posedge in_clk);
    if (m_pend) m_committed[m_pend_addr] = m_pend_data;
    if (m_pend && m_pend_ld) m_busy[m_pend_addr] = 1'b0;
    if (in_iss_valid && in_iss_is_load && !e_iss_stall && in_iss_rd != 5'd0) m_busy[in_iss_rd] = 1'b1;
    if (e_ld_rdy) m_starve = 0;
    else if (in_ld_valid && m_starve < STARVE_MAX) m_starve++;
    m_rdv = e_issue; m_en1 = e_issue && in_rs1_en; m_en2 = e_issue && in_rs2_en;
    m_exp1 = m_latest[in_rs1]; m_exp2 = m_latest[in_rs2];
    d = e_ld_rdy ? in_ld_data : in_wb_data;
    m_pend = e_acc && e_acc_addr != 5'd0; m_pend_ld = e_ld_rdy;
    m_pend_addr = e_acc_addr; m_pend_data = d;
    if (m_pend) m_latest[e_acc_addr] = d;
    @(negedge in_clk);
  endtask

  task automatic idle_inputs();
    in_wb_valid = 0; in_wb_addr = 0; in_wb_data = 0;
    in_ld_valid = 0; in_ld_addr = 0; in_ld_data = 0;
    in_iss_valid = 0; in_iss_rd = 0; in_iss_is_load = 0;
    in_rd_req = 0; in_rs1 = 0; in_rs1_en = 0; in_rs2 = 0; in_rs2_en = 0;
  endtask

  task automatic test_reset();
    in_rst = 1'b0; idle_inputs();
    #3;
    vectors++;
    if ({out_rf_wen, out_rf_waddr, out_rf_wdata, out_rdata_valid, out_busy} !== 71'd0) begin
      miscompares++;
      $display("FAIL reset_state: wen=%0b waddr=%0d wdata=%h rdv=%0b busy=%h required all zero",
               out_rf_wen, out_rf_waddr, out_rf_wdata, out_rdata_valid, out_busy);
    end
    in_wb_valid = 1; in_wb_addr = 5'd5; in_wb_data = 32'h1111_1111;
    @(posedge in_clk); #1;
    vectors++;
    if (out_rf_wen !== 1'b0) begin
      miscompares++; $display("FAIL reset_hold_wen: got %0b required 0", out_rf_wen);
    end
    @(negedge in_clk);
    idle_inputs(); in_rst = 1'b1; model_reset();
  endtask

  task automatic test_starvation();
    bit prev_ld;
    for (int c = 0; c < 10; c++) begin
      in_wb_valid = 1; in_wb_addr = 5'd1; in_wb_data = 32'(c);
      in_ld_valid = 1; in_ld_addr = 5'd2; in_ld_data = 32'h100 + 32'(c);
      #1;
      vectors++;
      if ({out_wb_ready, out_ld_ready} !== ((c % 5 == 4) ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL starve_arb cycle %0d: wb_ready=%0b ld_ready=%0b", c, out_wb_ready, out_ld_ready);
      end
      if (c > 0) begin
        vectors++;
        if (out_rf_wen !== 1'b1 || out_rf_waddr !== (prev_ld ? 5'd2 : 5'd1)) begin
          miscompares++;
          $display("FAIL starve_wr cycle %0d: wen=%0b waddr=%0d required 1/%0d", c, out_rf_wen,
                   out_rf_waddr, prev_ld ? 2 : 1);
        end
      end
      prev_ld = (c % 5 == 4);
      step();
    end
    idle_inputs(); step();
  endtask

  task automatic test_load_raw();
    in_iss_valid = 1; in_iss_rd = 5'd7; in_iss_is_load = 1;
    #1; vectors++;
    if (out_iss_stall !== 1'b0) begin miscompares++; $display("FAIL raw_iss: stall=%0b required 0", out_iss_stall); end
    step();
    idle_inputs(); in_rd_req = 1; in_rs1 = 5'd7; in_rs1_en = 1;
    for (int c = 0; c < 3; c++) begin
      #1; vectors++;
      if (out_busy[7] !== 1'b1 || out_rd_stall !== 1'b1 || out_rf_ren_1 !== 1'b0) begin
        miscompares++;
        $display("FAIL raw_wait: busy7=%0b stall=%0b ren1=%0b required 1/1/0", out_busy[7], out_rd_stall, out_rf_ren_1);
      end
      step();
    end
    in_ld_valid = 1; in_ld_addr = 5'd7; in_ld_data = 32'h1234_5678;
    #1; vectors++;
    if (out_ld_ready !== 1'b1 || out_rd_stall !== 1'b1) begin
      miscompares++; $display("FAIL raw_ld_acc: ld_ready=%0b stall=%0b required 1/1", out_ld_ready, out_rd_stall);
    end
    step();
    in_ld_valid = 0;
    #1; vectors++;
    if ({out_rf_wen, out_rf_waddr, out_rf_wdata, out_rd_stall, out_busy[7]} !== {1'b1, 5'd7, 32'h1234_5678, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL raw_pend: wen=%0b waddr=%0d wdata=%h stall=%0b busy7=%0b required 1/7/12345678/1/1",
               out_rf_wen, out_rf_waddr, out_rf_wdata, out_rd_stall, out_busy[7]);
    end
    step();
    #1; vectors++;
    if ({out_busy[7], out_rd_stall, out_rf_ren_1, out_rf_raddr_1} !== {1'b0, 1'b0, 1'b1, 5'd7}) begin
      miscompares++;
      $display("FAIL raw_issue: busy7=%0b stall=%0b ren1=%0b raddr1=%0d required 0/0/1/7",
               out_busy[7], out_rd_stall, out_rf_ren_1, out_rf_raddr_1);
    end
    step();
    idle_inputs();
    #1; vectors++;
    if (out_rdata_valid !== 1'b1 || rf_rdata_1 !== 32'h1234_5678) begin
      miscompares++; $display("FAIL raw_data: rdv=%0b data=%h required 1/12345678", out_rdata_valid, rf_rdata_1);
    end
    step();
  endtask

  task automatic test_waw();
    in_iss_valid = 1; in_iss_rd = 5'd3; in_iss_is_load = 1;
    step();
    in_iss_is_load = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin in_ld_valid = 1; in_ld_addr = 5'd3; in_ld_data = 32'hCAFE_0003; end
      else in_ld_valid = 0;
      #1; vectors++;
      if (out_iss_stall !== 1'b1) begin
        miscompares++; $display("FAIL waw_stall cycle %0d: stall=%0b required 1", c, out_iss_stall);
      end
      step();
    end
    #1; vectors++;
    if (out_iss_stall !== 1'b0 || out_busy[3] !== 1'b0) begin
      miscompares++; $display("FAIL waw_release: stall=%0b busy3=%0b required 0/0", out_iss_stall, out_busy[3]);
    end
    idle_inputs(); step();
  endtask

  task automatic test_x0();
    in_wb_valid = 1; in_wb_addr = 5'd0; in_wb_data = 32'hFFFF_FFFF;
    in_iss_valid = 1; in_iss_rd = 5'd0; in_iss_is_load = 1;
    in_rd_req = 1; in_rs1 = 5'd0; in_rs1_en = 1; in_rs2 = 5'd0; in_rs2_en = 1;
    #1; vectors++;
    if ({out_wb_ready, out_iss_stall, out_rd_stall, out_rf_ren_1} !== 4'b1001) begin
      miscompares++;
      $display("FAIL x0_accept: wb_ready=%0b iss_stall=%0b rd_stall=%0b ren1=%0b required 1/0/0/1",
               out_wb_ready, out_iss_stall, out_rd_stall, out_rf_ren_1);
    end
    step();
    in_wb_valid = 0; in_iss_valid = 0;
    #1; vectors++;
    if ({out_rf_wen, out_busy, out_rd_stall, out_rdata_valid, rf_rdata_1} !== {1'b0, 32'd0, 1'b0, 1'b1, 32'd0}) begin
      miscompares++;
      $display("FAIL x0_after: wen=%0b busy=%h stall=%0b rdv=%0b data=%h required 0/0/0/1/0",
               out_rf_wen, out_busy, out_rd_stall, out_rdata_valid, rf_rdata_1);
    end
    idle_inputs(); step();
  endtask

  task automatic test_pending_raw();
    logic [31:0] d;
    d = $urandom;
    in_wb_valid = 1; in_wb_addr = 5'd9; in_wb_data = d;
    in_rd_req = 1; in_rs2 = 5'd9; in_rs2_en = 1; in_rs1 = 5'd1; in_rs1_en = 1;
    for (int c = 0; c < 2; c++) begin
      #1; vectors++;
      if (out_rd_stall !== 1'b1 || out_rf_ren_2 !== 1'b0) begin
        miscompares++; $display("FAIL pend_raw_stall N+%0d: stall=%0b ren2=%0b required 1/0", c, out_rd_stall, out_rf_ren_2);
      end
      step();
      in_wb_valid = 0;
    end
    #1; vectors++;
    if (out_rd_stall !== 1'b0 || out_rf_ren_2 !== 1'b1 || out_rf_raddr_2 !== 5'd9) begin
      miscompares++;
      $display("FAIL pend_raw_issue: stall=%0b ren2=%0b raddr2=%0d required 0/1/9", out_rd_stall, out_rf_ren_2, out_rf_raddr_2);
    end
    step();
    idle_inputs();
    #1; vectors++;
    if (out_rdata_valid !== 1'b1 || rf_rdata_2 !== d) begin
      miscompares++; $display("FAIL pend_raw_data: rdv=%0b data=%h required 1/%h", out_rdata_valid, rf_rdata_2, d);
    end
    step();
  endtask

  task automatic test_random(int n);
    int la;
    for (int t = 0; t < n; t++) begin
      in_wb_valid = ($urandom_range(0, 99) < 40); in_wb_addr = 5'($urandom_range(0, 7)); in_wb_data = $urandom;
      in_ld_valid = ($urandom_range(0, 99) < 35); in_ld_data = $urandom;
      la = $urandom_range(0, 7);
      if (m_busy != 32'd0 && $urandom_range(0, 3) != 0)
        for (int k = 0; k < 32; k++) if (m_busy[(la + k) % 32]) begin la = (la + k) % 32; break; end
      in_ld_addr = 5'(la);
      in_iss_valid = ($urandom_range(0, 99) < 40); in_iss_rd = 5'($urandom_range(0, 7));
      in_iss_is_load = 1'($urandom_range(0, 1));
      in_rd_req = ($urandom_range(0, 99) < 60);
      in_rs1 = 5'($urandom_range(0, 7)); in_rs1_en = 1'($urandom_range(0, 1));
      in_rs2 = 5'($urandom_range(0, 7)); in_rs2_en = 1'($urandom_range(0, 1));
      #1; model_eval();
      vectors++;
      if ({out_wb_ready, out_ld_ready, out_iss_stall, out_rd_stall, out_rf_ren_1, out_rf_raddr_1, out_rf_ren_2, out_rf_raddr_2}
          !== {e_wb_rdy, e_ld_rdy, e_iss_stall, e_rd_stall, e_issue && in_rs1_en, e_issue ? in_rs1 : 5'd0,
               e_issue && in_rs2_en, e_issue ? in_rs2 : 5'd0}) begin
        miscompares++;
        $display("FAIL rand_comb t=%0d: wb=%0b ld=%0b iss=%0b rd=%0b ren=%0b%0b required %0b %0b %0b %0b %0b%0b", t,
                 out_wb_ready, out_ld_ready, out_iss_stall, out_rd_stall, out_rf_ren_1, out_rf_ren_2,
                 e_wb_rdy, e_ld_rdy, e_iss_stall, e_rd_stall, e_issue && in_rs1_en, e_issue && in_rs2_en);
      end
      vectors++;
      if (out_rf_wen !== m_pend || (m_pend && (out_rf_waddr !== m_pend_addr || out_rf_wdata !== m_pend_data))) begin
        miscompares++;
        $display("FAIL rand_write t=%0d: wen=%0b waddr=%0d wdata=%h required %0b/%0d/%h", t,
                 out_rf_wen, out_rf_waddr, out_rf_wdata, m_pend, m_pend_addr, m_pend_data);
      end
      vectors++;
      if (out_busy !== m_busy || out_rdata_valid !== m_rdv) begin
        miscompares++;
        $display("FAIL rand_state t=%0d: busy=%h rdv=%0b required %h/%0b", t, out_busy, out_rdata_valid, m_busy, m_rdv);
      end
      if (m_en1) begin
        vectors++;
        if (rf_rdata_1 !== m_exp1) begin
          miscompares++; $display("FAIL rand_rdata1 t=%0d: got %h required %h", t, rf_rdata_1, m_exp1);
        end
      end
      if (m_en2) begin
        vectors++;
        if (rf_rdata_2 !== m_exp2) begin
          miscompares++; $display("FAIL rand_rdata2 t=%0d: got %h required %h", t, rf_rdata_2, m_exp2);
        end
      end
      step();
    end
    idle_inputs(); step(); step();
  endtask

  task automatic test_reset_midwrite();
    in_wb_valid = 1; in_wb_addr = 5'd5; in_wb_data = 32'hA5A5_A5A5;
    in_iss_valid = 1; in_iss_rd = 5'd4; in_iss_is_load = 1;
    #1; vectors++;
    if (out_wb_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_accept: wb_ready=%0b required 1", out_wb_ready); end
    step();
    vectors++;
    if (out_rf_wen !== 1'b1 || out_busy[4] !== 1'b1) begin
      miscompares++; $display("FAIL midrst_pending: wen=%0b busy4=%0b required 1/1", out_rf_wen, out_busy[4]);
    end
    #2; idle_inputs(); in_rst = 1'b0;
    #1; vectors++;
    if (out_rf_wen !== 1'b0 || out_busy !== 32'd0 || out_rdata_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_drop: wen=%0b busy=%h rdv=%0b required 0/0/0", out_rf_wen, out_busy, out_rdata_valid);
    end
    @(posedge in_clk); @(negedge in_clk);
    vectors++;
    if (rf_mem[5] !== m_committed[5]) begin
      miscompares++; $display("FAIL midrst_x5: rf[5]=%h required %h", rf_mem[5], m_committed[5]);
    end
    in_rst = 1'b1; model_reset();
    step();
  endtask

  initial begin
    test_reset();
    test_starvation();
    test_load_raw();
    test_waw();
    test_x0();
    test_pending_raw();
    test_random(600);
    test_reset_midwrite();
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
